square_composer: RTL and testbench

SQUARE_COMPOSER -- requirements
Module: square_composer

---
 rtl/square_composer.sv | 93 +++++++++
 tb/tb_square_composer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/square_composer.sv
// Rebuilds a radicand from a (root, remainder) pair with a shift-and-add square.
// One result per operand pair, valid/ready on both sides, non-overlapped.
module square_composer #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din_valid,
  output logic                 din_ready,
  input  logic [WIDTH-1:0]     root,
  input  logic [2*WIDTH-1:0]   remainder,
  output logic                 dout_valid,
  input  logic                 dout_ready,
  output logic [2*WIDTH:0]     radicand,
  output logic                 canonical
);

  localparam int RW = 2*WIDTH + 1;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state;
  state_t state_n;

  logic [WIDTH-1:0]   root_q;
  logic [2*WIDTH-1:0] rem_q;
  logic [RW-1:0]      acc;
  logic [RW-1:0]      addend;
  logic [RW-1:0]      sum;
  logic [CW-1:0]      cnt;
  logic               last;

  assign din_ready  = (state == IDLE);
  assign dout_valid = (state == DONE);

  assign last   = (cnt == CW'(WIDTH-1));
  assign addend = root_q[cnt] ? (RW'(root_q) << cnt) : '0;
  assign sum    = acc + addend;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (din_valid) state_n = CALC;
      CALC: if (last) state_n = DONE;
      DONE: if (dout_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Outputs update only on the CALC->DONE edge so they hold elsewhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      root_q    <= '0;
      rem_q     <= '0;
      acc       <= '0;
      cnt       <= '0;
      radicand  <= '0;
      canonical <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (din_valid) begin
            root_q <= root;
            rem_q  <= remainder;
            acc    <= RW'(remainder);
            cnt    <= '0;
          end
        end
        CALC: begin
          acc <= sum;
          cnt <= cnt + CW'(1);
          if (last) begin
            radicand  <= sum;
            canonical <= (rem_q <= (2*WIDTH)'({root_q, 1'b0}));
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_square_composer.sv
// Randomised scoreboard bench for square_composer (WIDTH = 4).
// Driver pushes arithmetic expectations; a negedge monitor pops and compares.
module tb_square_composer;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           din_valid = 1'b0;
  logic           din_ready;
  logic [W-1:0]   root = '0;
  logic [2*W-1:0] remainder = '0;
  logic           dout_valid;
  logic           dout_ready = 1'b0;
  logic [2*W:0]   radicand;
  logic           canonical;

  square_composer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .root       (root),
    .remainder  (remainder),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .radicand   (radicand),
    .canonical  (canonical)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rad;
    int canon;
    int acc_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   rdy_mode = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, req, cyc);
    end
  endtask

  // 0: always ready, 1: random stalls, 2: held low
  always begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: dout_ready = 1'b1;
      1: dout_ready = ($urandom_range(0, 3) != 0);
      default: dout_ready = 1'b0;
    endcase
  end

  bit prev_v   = 0;
  bit chk_next = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_v   = 0;
      chk_next = 0;
    end else begin
      if (chk_next) begin
        check("din_ready_after_xfer", int'(din_ready), 1);
        check("dout_valid_after_xfer", int'(dout_valid), 0);
        chk_next = 0;
      end
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_dout_valid", 1, 0);
        end else begin
          if (!prev_v)
            check("latency", cyc - exp_q[0].acc_cyc, W);
          check("radicand", int'(radicand), exp_q[0].rad);
          check("canonical", int'(canonical), exp_q[0].canon);
          check("din_ready_busy", int'(din_ready), 0);
          if (dout_ready) begin
            void'(exp_q.pop_front());
            chk_next = 1;
          end
        end
      end
      prev_v = dout_valid && !dout_ready;
    end
  end

  task automatic send(int r, int m);
    int t;
    exp_t e;
    t = 0;
    while (!din_ready && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!din_ready) begin
      check("din_ready_timeout", 0, 1);
      return;
    end
    din_valid = 1'b1;
    root      = W'(r);
    remainder = (2*W)'(m);
    @(posedge clk);
    #1;
    e.rad     = r * r + m;
    e.canon   = (m <= 2 * r) ? 1 : 0;
    e.acc_cyc = cyc;
    exp_q.push_back(e);
    din_valid = 1'b0;
    root      = W'($urandom);
    remainder = (2*W)'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic check_reset_state(string tag);
    @(negedge clk);
    check({tag, "_dout_valid"}, int'(dout_valid), 0);
    check({tag, "_radicand"}, int'(radicand), 0);
    check({tag, "_canonical"}, int'(canonical), 0);
    check({tag, "_din_ready"}, int'(din_ready), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r;
    int t;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    rst = 1'b0;
    check_reset_state("reset");

    rdy_mode = 0;
    send(13, 7);
    send(2, 200);
    send(15, 255);
    send(0, 0);
    send(15, 30);
    send(15, 31);
    drain();

    // Long backpressure in DONE
    rdy_mode = 2;
    send(9, 5);
    t = 0;
    while (!dout_valid && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("stall_reach_done", int'(dout_valid), 1);
    repeat (5) @(posedge clk);
    #1;
    rdy_mode = 0;
    drain();

    // Reset sampled on CALC step 2
    send(11, 3);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("midcalc");
    repeat (8) @(posedge clk);
    #1;
    send(7, 14);
    drain();

    rdy_mode = 1;
    for (int n = 0; n < 256; n++) begin
      r = 0;
      while ((r + 1) * (r + 1) <= n) r++;
      send(r, n - r * r);
    end
    for (int k = 0; k < 40; k++)
      send(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
